// File: rtl/mm_lane_sequencer.sv
// rtl/mm_lane_sequencer.sv - one-hot lane sequencer for the M/m processing datapath
//
// Purpose: on an accepted start, latches the dimensions M and m and steps a
// one-hot lane select from lane 0 up to lane max(M,m). The select advances one
// lane per beat accepted by the datapath, then pulses done.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, abort         controller requests (start sampled only in IDLE)
//   M, m                 dimensions, latched on an accepted start
//   lane_ready           datapath accepts the current beat
//   lane_valid, lane_sel current beat and its one-hot lane select
//   row_en, col_en       lane index still within M_r / m_r
//   busy, done           controller status
//   stall_cnt            saturating count of RUN cycles with lane_ready low

module mm_lane_sequencer #(
    parameter int IDX_W = 3,
    parameter int LANES = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [IDX_W-1:0] M,
    input  logic [IDX_W-1:0] m,
    input  logic             lane_ready,
    output logic             lane_valid,
    output logic [LANES-1:0] lane_sel,
    output logic             row_en,
    output logic             col_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] m_big_r;
    logic [IDX_W-1:0] m_small_r;
    logic [IDX_W-1:0] max_r;

    // Start with abort high at the same time is refused outright.
    logic start_ok;
    logic last_beat;

    assign start_ok  = start && !abort;
    assign last_beat = lane_ready && (idx == max_r);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (last_beat) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Lane index, latched dimensions and stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            m_big_r   <= '0;
            m_small_r <= '0;
            max_r     <= '0;
            stall_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        m_big_r   <= M;
                        m_small_r <= m;
                        max_r     <= (M > m) ? M : m;
                        idx       <= '0;
                        stall_cnt <= '0;
                    end
                end
                S_RUN: begin
                    // abort wins over lane_ready and freezes the stall count
                    if (abort) begin
                        idx <= '0;
                    end else if (lane_ready) begin
                        if (last_beat) begin
                            idx <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else if (stall_cnt != {CNT_W{1'b1}}) begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode from registers only
    always_comb begin
        lane_valid = 1'b0;
        lane_sel   = '0;
        row_en     = 1'b0;
        col_en     = 1'b0;
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        if (state == S_RUN) begin
            lane_valid = 1'b1;
            lane_sel   = {{(LANES-1){1'b0}}, 1'b1} << idx;
            row_en     = (idx <= m_big_r);
            col_en     = (idx <= m_small_r);
        end
    end

endmodule

// File: tb/tb_mm_lane_sequencer.sv
// tb/tb_mm_lane_sequencer.sv - scoreboard bench for mm_lane_sequencer

module tb_mm_lane_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] M = 3'd0;
    logic [2:0] m = 3'd0;
    logic       lane_ready = 1'b0;
    logic       lane_valid;
    logic [7:0] lane_sel;
    logic       row_en;
    logic       col_en;
    logic       busy;
    logic       done;
    logic [7:0] stall_cnt;

    mm_lane_sequencer #(.IDX_W(3), .LANES(8), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .M          (M),
        .m          (m),
        .lane_ready (lane_ready),
        .lane_valid (lane_valid),
        .lane_sel   (lane_sel),
        .row_en     (row_en),
        .col_en     (col_en),
        .busy       (busy),
        .done       (done),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_done;
        logic [7:0] sel;
        logic       row;
        logic       col;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   done_seen = 0;
    int   last_done_cyc = -1;
    int   last_beat_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every accepted beat and every done pulse against the queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (lane_valid && lane_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {24'd0, lane_sel}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("beat_kind", 32'(e.is_done), 32'd0);
                    chk("beat_sel", {24'd0, lane_sel}, {24'd0, e.sel});
                    chk("beat_row_col", {30'd0, row_en, col_en}, {30'd0, e.row, e.col});
                end
                last_beat_cyc = cyc;
            end else if (lane_valid && exp_q.size() != 0) begin
                chk("stall_sel_held", {24'd0, lane_sel}, {24'd0, exp_q[0].sel});
            end
            if (done) begin
                done_seen++;
                last_done_cyc = cyc;
                chk("done_busy", {30'd0, busy, lane_valid}, 32'd2);
                chk("done_after_last_beat", cyc, last_beat_cyc + 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_kind", 32'(e.is_done), 32'd1);
                end
            end
        end
    end

    task automatic push_beats(input int mm, input int ms, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            exp_t e;
            e.is_done = 1'b0;
            e.sel     = 8'(1 << i);
            e.row     = (i <= mm);
            e.col     = (i <= ms);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1;
        e.sel     = 8'd0;
        e.row     = 1'b0;
        e.col     = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [2:0] a, input logic [2:0] b);
        M = a;
        m = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        if (busy) chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_sel(input string name, input logic [7:0] s);
        int n = 0;
        while (lane_sel !== s && n < 50) begin
            tick();
            n++;
        end
        if (lane_sel !== s) chk({name, "_timeout"}, {24'd0, lane_sel}, {24'd0, s});
    endtask

    // Full sequence with lane_ready held high; checks done latency
    task automatic run_seq(input string name, input int a, input int b);
        int t0;
        int mx;
        mx = (a > b) ? a : b;
        push_beats(a, b, 0, mx);
        push_done();
        lane_ready = 1'b1;
        t0 = cyc;
        pulse_start(3'(a), 3'(b));
        wait_idle(name);
        chk({name, "_done_latency"}, last_done_cyc, t0 + mx + 2);
    endtask

    initial begin
        int d0;
        #2;
        chk("reset_outputs", {20'd0, lane_valid, lane_sel, row_en, col_en, busy, done},
            32'd0);
        chk("reset_stall", {24'd0, stall_cnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // T1 then T2 back-to-back with no idle gap
        run_seq("t1", 3, 5);
        run_seq("t2", 0, 0);
        chk("t2_stall", {24'd0, stall_cnt}, 32'd0);

        // start with abort in IDLE is refused
        abort = 1'b1;
        pulse_start(3'd4, 3'd4);
        abort = 1'b0;
        chk("start_abort_idle", {31'd0, busy}, 32'd0);

        // T3: stall three cycles on beat 4
        push_beats(7, 2, 0, 7);
        push_done();
        lane_ready = 1'b1;
        pulse_start(3'd7, 3'd2);
        wait_sel("t3", 8'h10);
        lane_ready = 1'b0;
        repeat (3) tick();
        chk("t3_stall_mid", {24'd0, stall_cnt}, 32'd3);
        chk("t3_sel_held", {24'd0, lane_sel}, 32'h10);
        lane_ready = 1'b1;
        wait_idle("t3");
        chk("t3_stall_final", {24'd0, stall_cnt}, 32'd3);

        // T4: start mid-RUN is ignored
        begin
            int t0;
            push_beats(2, 4, 0, 4);
            push_done();
            t0 = cyc;
            pulse_start(3'd2, 3'd4);
            tick();
            pulse_start(3'd7, 3'd7);
            wait_idle("t4");
            chk("t4_done_latency", last_done_cyc, t0 + 4 + 2);
        end

        // T5: abort on beat 2, no done, then a clean run
        d0 = done_seen;
        push_beats(6, 1, 0, 1);
        pulse_start(3'd6, 3'd1);
        wait_sel("t5", 8'h04);
        abort = 1'b1;
        lane_ready = 1'b0;
        tick();
        abort = 1'b0;
        chk("t5_abort_idle", {30'd0, lane_valid, busy}, 32'd0);
        chk("t5_stall_held", {24'd0, stall_cnt}, 32'd0);
        repeat (4) tick();
        chk("t5_no_done", done_seen, d0);
        run_seq("t5b", 1, 3);

        // T6: reset mid-RUN after a short stall
        d0 = done_seen;
        push_beats(5, 5, 0, 2);
        lane_ready = 1'b1;
        pulse_start(3'd5, 3'd5);
        wait_sel("t6", 8'h08);
        lane_ready = 1'b0;
        repeat (2) tick();
        chk("t6_stall_pre", {24'd0, stall_cnt}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_outputs", {20'd0, lane_valid, lane_sel, row_en, col_en, busy, done},
            32'd0);
        chk("t6_async_stall", {24'd0, stall_cnt}, 32'd0);
        repeat (2) tick();
        chk("t6_reset_hold", {21'd0, lane_valid, lane_sel, busy, done}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("t6_after_reset", {30'd0, busy, done}, 32'd0);
        chk("t6_no_done", done_seen, d0);

        // Saturation: 300 stalled cycles on beat 0
        push_beats(1, 0, 0, 1);
        push_done();
        lane_ready = 1'b0;
        pulse_start(3'd1, 3'd0);
        repeat (300) tick();
        chk("sat_stall", {24'd0, stall_cnt}, 32'd255);
        chk("sat_sel", {24'd0, lane_sel}, 32'h01);
        lane_ready = 1'b1;
        wait_idle("sat");
        chk("sat_stall_after", {24'd0, stall_cnt}, 32'd255);

        tick();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
